screen_sequencer: RTL and testbench
===================================

// Module: screen_sequencer
// PURPOSE
//  Game-flow controller that drives the 6-bit screen code into multidisplay.
//  Sequences the idle (blank) state, the 3-2-1-GO countdown, tug-of-war play and the win screens.
//  During play it moves the barrier position on player button pulses.
//  Sits between the debounced button front-end and the display block, and is its sole screen source.
// PARAMETERS
//  STEP_TICKS  1_000_000  clk cycles each countdown screen (3, 2, 1, GO) is held; must be >= 2
//  POS_MIN     16         lowest play position; a P2 press here gives P2 the win
//  POS_MAX     30         highest play position; a P1 press here gives P1 the win
//  POS_INIT    23         barrier position loaded on entry to PLAY
// PORTS
//  clk       in   1  system clock; all state changes on the posedge
//  reset     in   1  asynchronous, active-high reset
//  start     in   1  single-cycle pulse; starts a game from IDLE or a win state
//  p1_press  in   1  single-cycle pulse, debounced and synchronised; P1 pushes barrier up
//  p2_press  in   1  single-cycle pulse, debounced and synchronised; P2 pushes barrier down
//  screen    out  6  registered screen code to multidisplay
//  playing   out  1  high exactly while in PLAY
//  winner    out  2  00 none, 01 P1, 10 P2; held until the next start or reset
// BEHAVIOUR
//  Reset (async): state=IDLE, screen=0, playing=0, winner=00, pos=POS_INIT, timer=0.
//  States and screen codes:
//   IDLE=0, CNT3=34, CNT2=33, CNT1=32, GO=31, PLAY=pos, P2WIN=35, P1WIN=36.
//  All outputs are registered and change on the same edge as the state register.
//  IDLE:
//   start -> CNT3 and timer cleared.
//  CNT3, CNT2, CNT1, GO:
//   - timer counts 0..STEP_TICKS-1; each state lasts exactly STEP_TICKS cycles.
//   - at terminal count, advance CNT3 -> CNT2 -> CNT1 -> GO -> PLAY and clear timer.
//   - on GO -> PLAY, pos is loaded with POS_INIT, so screen=POS_INIT on the first PLAY cycle.
//  PLAY (one-cycle latency: the edge that samples a press also updates screen):
//   - p1_press only:
//       pos<POS_MAX  -> pos+1
//       pos==POS_MAX -> P1WIN, winner=01
//   - p2_press only:
//       pos>POS_MIN  -> pos-1
//       pos==POS_MIN -> P2WIN, winner=10
//   - both presses in the same cycle: they cancel; pos unchanged, no win.
//   - pos never leaves POS_MIN..POS_MAX, and the timer is idle.
//  P1WIN, P2WIN:
//   - the screen holds until start, which goes to CNT3 with winner=00 and timer=0.
//  Ignored inputs:
//   - p1_press and p2_press are ignored outside PLAY.
//   - start is ignored in CNT*, GO and PLAY.
//  Reset asserted mid-countdown or mid-play returns to IDLE immediately (async); no partial state is kept.
//  Arithmetic:
//   - pos is 6 bits unsigned.
//   - the timer is $clog2(STEP_TICKS) bits and wraps only via an explicit clear.
//  The screen code is always in {0, 16..36}; no other value is ever driven.
// STRUCTURE
//  screen_pkg:
//   - typedef enum logic[2:0] game_state_t {IDLE, CNT3, CNT2, CNT1, GO, PLAY, P1WIN, P2WIN}.
//   - localparams SCR_BLANK=0, SCR_GO=31, SCR_ONE=32, SCR_TWO=33, SCR_THREE=34,
//     SCR_P2WIN=35, SCR_P1WIN=36.
//   - multidisplay decodes these same constants.
//  Sub-module step_timer (params TICKS; ports clk, reset, clear, en, done):
//   - a terminal-count counter instantiated once.
//   - done is high on the cycle where count==TICKS-1 and en=1.
//  Top level holds the state FSM, the pos register and the output registers.
// TESTING
//  Test parameters: STEP_TICKS=4, POS_MIN=16, POS_MAX=30, POS_INIT=23.
//  1. Countdown timing:
//     start pulse in IDLE -> screen sequence 34, 33, 32, 31, each for exactly 4 cycles,
//     then screen=23 and playing=1.
//  2. P1 win:
//     7 p1_press pulses in PLAY -> screen steps 24..30.
//     8th press -> screen=36, winner=01, playing=0; further presses leave screen=36.
//  3. P2 win and simultaneous presses:
//     - p1_press and p2_press together at pos 23 -> screen stays 23.
//     - then 7 p2_press pulses -> screen reaches 16.
//     - the next p2_press -> screen=35, winner=10.
//  4. Ignored inputs:
//     - presses during the countdown leave the countdown timing unchanged and PLAY still starts at 23.
//     - start during PLAY has no effect.
//  5. Reset mid-operation:
//     - assert reset asynchronously mid-CNT2 -> screen=0, winner=00 without waiting for a clock edge.
//     - assert reset at pos 27 in PLAY -> same result; a following start restarts at 34.
//  6. Restart from a win:
//     start in P1WIN -> winner=00, screen=34 on the next edge, full countdown, pos=23 again.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared screen codes and game states for the sequencer and multidisplay.
// Both blocks decode the same constants, so they live here.
package screen_pkg;

    typedef enum logic [2:0] {IDLE, CNT3, CNT2, CNT1, GO, PLAY, P1WIN, P2WIN} game_state_t;

    localparam logic [5:0] SCR_BLANK = 6'd0;
    localparam logic [5:0] SCR_GO    = 6'd31;
    localparam logic [5:0] SCR_ONE   = 6'd32;
    localparam logic [5:0] SCR_TWO   = 6'd33;
    localparam logic [5:0] SCR_THREE = 6'd34;
    localparam logic [5:0] SCR_P2WIN = 6'd35;
    localparam logic [5:0] SCR_P1WIN = 6'd36;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/screen_sequencer_step_timer.sv
// Terminal-count timer for the countdown screens; done pulses on the last tick.
// The owner clears it explicitly, so it never wraps on its own.
module step_timer #(
    parameter int TICKS = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);
    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] count;

    assign done = en && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      count <= '0;
        else if (clear) count <= '0;
        else if (en)    count <= count + 1'b1;
    end
endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller: idle, 3-2-1-GO countdown, tug-of-war play, win screens.
// Screen, playing and winner are registered from the next-state values.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int STEP_TICKS = 1_000_000,
    parameter int POS_MIN    = 16,
    parameter int POS_MAX    = 30,
    parameter int POS_INIT   = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_press,
    input  logic       p2_press,
    output logic [5:0] screen,
    output logic       playing,
    output logic [1:0] winner
);
    localparam logic [5:0] PMIN  = 6'(POS_MIN);
    localparam logic [5:0] PMAX  = 6'(POS_MAX);
    localparam logic [5:0] PINIT = 6'(POS_INIT);

    game_state_t state, state_d;
    logic [5:0]  pos, pos_d, screen_d;
    logic [1:0]  winner_d;
    logic        tmr_clear, tmr_en, tmr_done;

    assign tmr_en = (state == CNT3) || (state == CNT2) || (state == CNT1) || (state == GO);

    step_timer #(.TICKS(STEP_TICKS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .en    (tmr_en),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state;
        pos_d     = pos;
        winner_d  = winner;
        tmr_clear = 1'b0;
        case (state)
            IDLE: if (start) begin state_d = CNT3; tmr_clear = 1'b1; end
            CNT3: if (tmr_done) begin state_d = CNT2; tmr_clear = 1'b1; end
            CNT2: if (tmr_done) begin state_d = CNT1; tmr_clear = 1'b1; end
            CNT1: if (tmr_done) begin state_d = GO;   tmr_clear = 1'b1; end
            GO: if (tmr_done) begin
                state_d   = PLAY;
                pos_d     = PINIT;
                tmr_clear = 1'b1;
            end
            PLAY: begin
                // Simultaneous presses cancel, so only a lone press moves the barrier.
                if (p1_press && !p2_press) begin
                    if (pos >= PMAX) begin state_d = P1WIN; winner_d = WIN_P1; end
                    else pos_d = pos + 6'd1;
                end else if (p2_press && !p1_press) begin
                    if (pos <= PMIN) begin state_d = P2WIN; winner_d = WIN_P2; end
                    else pos_d = pos - 6'd1;
                end
            end
            P1WIN, P2WIN: if (start) begin
                state_d   = CNT3;
                winner_d  = WIN_NONE;
                tmr_clear = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            CNT3:    screen_d = SCR_THREE;
            CNT2:    screen_d = SCR_TWO;
            CNT1:    screen_d = SCR_ONE;
            GO:      screen_d = SCR_GO;
            PLAY:    screen_d = pos_d;
            P1WIN:   screen_d = SCR_P1WIN;
            P2WIN:   screen_d = SCR_P2WIN;
            default: screen_d = SCR_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pos     <= PINIT;
            screen  <= SCR_BLANK;
            playing <= 1'b0;
            winner  <= WIN_NONE;
        end else begin
            state   <= state_d;
            pos     <= pos_d;
            screen  <= screen_d;
            playing <= (state_d == PLAY);
            winner  <= winner_d;
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer; expected outputs are queued with each
// stimulus step and popped for comparison after the sampling edge.
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, p1_press = 1'b0, p2_press = 1'b0;
    logic [5:0] screen;
    logic       playing;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [5:0] scr;
        logic       play;
        logic [1:0] win;
    } exp_t;

    exp_t sb[$];

    screen_sequencer #(
        .STEP_TICKS(4), .POS_MIN(16), .POS_MAX(30), .POS_INIT(23)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_press(p1_press), .p2_press(p2_press),
        .screen(screen), .playing(playing), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [5:0] es,
                              input logic ep, input logic [1:0] ew);
        exp_t e;
        e.tag = tag; e.scr = es; e.play = ep; e.win = ew;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        assert (screen === e.scr && playing === e.play && winner === e.win) else begin
            errors++;
            $error("FAIL %s observed scr=%0d play=%0b win=%0b expected scr=%0d play=%0b win=%0b",
                   e.tag, screen, playing, winner, e.scr, e.play, e.win);
        end
    endtask

    // One clock of stimulus; outputs checked just after the sampling edge.
    task automatic step(input string tag, input logic s, input logic a, input logic b,
                        input logic [5:0] es, input logic ep, input logic [1:0] ew);
        @(negedge clk);
        start = s; p1_press = a; p2_press = b;
        expect_out(tag, es, ep, ew);
        @(posedge clk);
        #1;
        start = 1'b0; p1_press = 1'b0; p2_press = 1'b0;
        check_head();
    endtask

    // Remainder of a countdown after the start edge, ending on the first PLAY cycle.
    task automatic countdown(input string tag, input bit noise);
        logic [5:0] codes [4];
        int n = 0;
        codes[0] = 6'd34; codes[1] = 6'd33; codes[2] = 6'd32; codes[3] = 6'd31;
        for (int c = 0; c < 4; c++) begin
            for (int k = (c == 0) ? 1 : 0; k < 4; k++) begin
                if (noise) step(tag, (n % 3) == 0, (n % 2) == 0, (n % 4) == 1, codes[c], 1'b0, 2'b00);
                else       step(tag, 1'b0, 1'b0, 1'b0, codes[c], 1'b0, 2'b00);
                n++;
            end
        end
        step({tag, "_play"}, 1'b0, 1'b0, 1'b0, 6'd23, 1'b1, 2'b00);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        expect_out(tag, 6'd0, 1'b0, 2'b00);
        #1;
        check_head();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        expect_out("reset_state", 6'd0, 1'b0, 2'b00);
        check_head();
        @(negedge clk);
        reset = 1'b0;
        step("idle_hold", 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'b00);

        // Countdown timing
        step("start_cnt3", 1'b1, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00);
        countdown("cd1", 1'b0);

        // P1 climbs to the top and wins
        for (int i = 0; i < 7; i++) step("p1_up", 1'b0, 1'b1, 1'b0, 6'(24 + i), 1'b1, 2'b00);
        step("p1_win", 1'b0, 1'b1, 1'b0, 6'd36, 1'b0, 2'b01);
        step("p1_win_hold_p1", 1'b0, 1'b1, 1'b0, 6'd36, 1'b0, 2'b01);
        step("p1_win_hold_p2", 1'b0, 1'b0, 1'b1, 6'd36, 1'b0, 2'b01);

        // Restart from a win, with presses and start noise during the countdown
        step("restart_p1win", 1'b1, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00);
        countdown("cd_noise", 1'b1);

        // Simultaneous presses cancel; start in PLAY is ignored
        step("both_cancel", 1'b0, 1'b1, 1'b1, 6'd23, 1'b1, 2'b00);
        step("start_in_play", 1'b1, 1'b0, 1'b0, 6'd23, 1'b1, 2'b00);
        for (int i = 0; i < 7; i++) step("p2_down", 1'b0, 1'b0, 1'b1, 6'(22 - i), 1'b1, 2'b00);
        step("p2_win", 1'b0, 1'b0, 1'b1, 6'd35, 1'b0, 2'b10);
        step("p2_win_hold", 1'b0, 1'b0, 1'b0, 6'd35, 1'b0, 2'b10);

        // Async reset mid-CNT2
        step("restart_p2win", 1'b1, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) step("cnt3_again", 1'b0, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00);
        step("cnt2_a", 1'b0, 1'b0, 1'b0, 6'd33, 1'b0, 2'b00);
        step("cnt2_b", 1'b0, 1'b0, 1'b0, 6'd33, 1'b0, 2'b00);
        async_reset_check("reset_mid_cnt2");
        step("idle_after_reset", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'b00);

        // Full countdown after reset, then reset at pos 27 in PLAY
        step("start_after_reset", 1'b1, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00);
        countdown("cd2", 1'b0);
        for (int i = 0; i < 4; i++) step("p1_to_27", 1'b0, 1'b1, 1'b0, 6'(24 + i), 1'b1, 2'b00);
        async_reset_check("reset_mid_play");
        step("restart_after_play_reset", 1'b1, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00);
        countdown("cd3", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
